// File: rtl/serial_msg_pkg.sv
// Shared constants and FSM state encoding for the serial message transmitter.
package serial_msg_pkg;

  localparam int MSG_W = 5;
  localparam int DIV_W = 10;
  localparam logic [DIV_W-1:0] DIV_RST = 10'd9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic even_parity(input logic [MSG_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/serial_msg_tx_baud_tick_gen.sv
// Bit-period generator: holds the divisor and a down-counter.
// bit_end_o pulses for one cycle when the current bit has lasted DIV+1 cycles.
module baud_tick_gen
  import serial_msg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             init_i,
  input  logic [DIV_W-1:0] sw_i,
  input  logic             reload_i,
  output logic             bit_end_o
);

  localparam logic [DIV_W-1:0] ONE = 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;

  // Divisor written by init takes effect at the next reload, so an init on
  // the same edge as a reload (frame start or bit end) already applies.
  always_comb begin
    div_d     = init_i ? sw_i : div_q;
    bit_end_o = (cnt_q == '0);
    cnt_d     = (reload_i || bit_end_o) ? div_d : (cnt_q - ONE);
  end

  // Divisor and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= DIV_RST;
      cnt_q <= '0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_msg_tx.sv
// Framed serial transmitter: start bit, 5 data bits, optional even parity,
// stop bit. Bit length comes from the programmable divisor in baud_tick_gen.
module serial_msg_tx
  import serial_msg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic [DIV_W-1:0] SW,
  input  logic             start,
  input  logic [MSG_W-1:0] msg,
  input  logic             mode,
  input  logic             sel,
  output logic             out
);

  localparam logic [2:0] LAST_BIT = 3'(MSG_W - 1);

  state_t           state_q;
  logic [MSG_W-1:0] shift_q;
  logic [MSG_W-1:0] shift_d;
  logic [2:0]       bit_cnt_q;
  logic             mode_q;
  logic             sel_q;
  logic             par_q;
  logic             out_q;
  logic             data_bit;
  logic             reload;
  logic             bit_end;

  // Frame starts only from IDLE; the tick counter restarts on that edge.
  assign reload = (state_q == IDLE) && start;

  // Next data bit comes from the end selected by the captured bit order.
  always_comb begin
    data_bit = mode_q ? shift_q[MSG_W-1] : shift_q[0];
    shift_d  = mode_q ? {shift_q[MSG_W-2:0], 1'b0} : {1'b0, shift_q[MSG_W-1:1]};
  end

  baud_tick_gen u_tick (
    .clk       (clk),
    .rst       (rst),
    .init_i    (init),
    .sw_i      (SW),
    .reload_i  (reload),
    .bit_end_o (bit_end)
  );

  // Frame FSM with registered serial output; each output value is set on the
  // edge that enters the bit it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      out_q     <= 1'b1;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      mode_q    <= 1'b0;
      sel_q     <= 1'b0;
      par_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          out_q <= 1'b1;
          if (start) begin
            shift_q   <= msg;
            mode_q    <= mode;
            sel_q     <= sel;
            par_q     <= even_parity(msg);
            bit_cnt_q <= '0;
            out_q     <= 1'b0;
            state_q   <= START;
          end
        end
        START: begin
          if (bit_end) begin
            out_q     <= data_bit;
            shift_q   <= shift_d;
            bit_cnt_q <= '0;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt_q == LAST_BIT) begin
              if (sel_q) begin
                out_q   <= par_q;
                state_q <= PARITY;
              end else begin
                out_q   <= 1'b1;
                state_q <= STOP;
              end
            end else begin
              out_q     <= data_bit;
              shift_q   <= shift_d;
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            out_q   <= 1'b1;
            state_q <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            out_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          out_q   <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_serial_msg_tx.sv
// Directed bench for serial_msg_tx: every sampled cycle of out is compared
// against a hand-written frame pattern.
module tb_serial_msg_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       init;
  logic [9:0] SW;
  logic       start;
  logic [4:0] msg;
  logic       mode;
  logic       sel;
  logic       out;

  int errors = 0;
  int checks = 0;

  serial_msg_tx dut (
    .clk   (clk),
    .rst   (rst),
    .init  (init),
    .SW    (SW),
    .start (start),
    .msg   (msg),
    .mode  (mode),
    .sel   (sel),
    .out   (out)
  );

  // Clock: 10 ns period.
  always #5 clk = ~clk;

  // Check out for n consecutive cycles, sampled on the falling edge.
  task automatic expect_bit(input logic val, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      assert (out === val)
      else begin
        errors++;
        $error("FAIL %s: out=%b expected %b (cycle %0d)", tag, out, val, i);
      end
    end
  endtask

  // bits[nbits-1] is the first bit on the line.
  task automatic expect_frame(input logic [7:0] bits, input int nbits,
                              input int per, input string tag);
    for (int b = nbits - 1; b >= 0; b--) expect_bit(bits[b], per, tag);
  endtask

  // One-cycle start pulse, optionally with init/SW on the same edge.
  task automatic launch(input logic [4:0] m, input logic md, input logic s,
                        input logic do_init, input logic [9:0] sw);
    @(posedge clk);
    #1;
    msg   = m;
    mode  = md;
    sel   = s;
    init  = do_init;
    SW    = sw;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    init  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; init = 1'b0; SW = '0; start = 1'b1;
    msg = 5'b11111; mode = 1'b0; sel = 1'b0;

    // Reset held two edges with start high: line stays idle.
    @(posedge clk);
    expect_bit(1'b1, 2, "reset_idle");
    rst = 1'b0; start = 1'b0;
    expect_bit(1'b1, 2, "post_reset_idle");

    // Reset divisor 9: 10 cycles per bit, LSB first.
    launch(5'b10101, 1'b0, 1'b0, 1'b0, 10'd0);
    expect_frame(8'b0101011, 7, 10, "div_rst_frame");
    expect_bit(1'b1, 2, "idle_after_rst_frame");

    // Divisor 3 loaded with the start pulse: 4 cycles per bit.
    launch(5'b10101, 1'b0, 1'b0, 1'b1, 10'd3);
    expect_frame(8'b0101011, 7, 4, "div3_lsb");
    expect_bit(1'b1, 3, "idle_after_div3");

    // Divisor 0, MSB first: 1 cycle per bit.
    launch(5'b10011, 1'b1, 1'b0, 1'b1, 10'd0);
    expect_frame(8'b0100111, 7, 1, "div0_msb");
    expect_bit(1'b1, 3, "idle_after_div0");

    // Divisor 1 with parity: three ones -> parity 1.
    launch(5'b10101, 1'b0, 1'b1, 1'b1, 10'd1);
    expect_frame(8'b01010111, 8, 2, "parity_one");
    expect_bit(1'b1, 2, "idle_after_par1");

    // Two ones -> parity 0; divisor unchanged.
    launch(5'b00011, 1'b0, 1'b1, 1'b0, 10'd0);
    expect_frame(8'b01100001, 8, 2, "parity_zero");
    expect_bit(1'b1, 2, "idle_after_par0");

    // Mid-frame disturbance at divisor 3: start, msg, mode and a new divisor
    // of 0 during data bit 1. Bit 1 keeps 4 cycles, later bits take 1 cycle.
    launch(5'b10101, 1'b0, 1'b0, 1'b1, 10'd3);
    expect_bit(1'b0, 4, "busy_start");
    expect_bit(1'b1, 4, "busy_d0");
    expect_bit(1'b0, 1, "busy_d1_head");
    start = 1'b1; msg = 5'b11111; mode = 1'b1; init = 1'b1; SW = 10'd0;
    @(posedge clk);
    #1;
    start = 1'b0; init = 1'b0;
    expect_bit(1'b0, 3, "busy_d1_tail");
    expect_bit(1'b1, 1, "busy_d2");
    expect_bit(1'b0, 1, "busy_d3");
    expect_bit(1'b1, 1, "busy_d4");
    expect_bit(1'b1, 1, "busy_stop");
    expect_bit(1'b1, 6, "busy_no_second_frame");

    // Reset during data bit 2 of a divisor-3 frame.
    launch(5'b00100, 1'b0, 1'b0, 1'b1, 10'd3);
    expect_bit(1'b0, 4, "abort_start");
    expect_bit(1'b0, 4, "abort_d0");
    expect_bit(1'b0, 4, "abort_d1");
    expect_bit(1'b1, 1, "abort_d2");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    expect_bit(1'b1, 6, "abort_idle");

    // Fresh frame after the abort runs at the reset divisor.
    launch(5'b10101, 1'b0, 1'b0, 1'b0, 10'd0);
    expect_frame(8'b0101011, 7, 10, "after_abort_frame");
    expect_bit(1'b1, 2, "final_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
